// File: rtl/fetch_unit_if.sv
// Fetch-unit port bundle: decoder/ALU controls, LUT write port and fetch outputs.
// Latency: none, this is wiring only.
// Backpressure: none, every signal is sampled or driven once per cycle.
interface fetch_unit_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5,
  parameter int CNT_W  = 16
) ();

  logic              Start;
  logic [PC_W-1:0]   StartAddr;
  logic              Jump;
  logic              BranchEn;
  logic              Zero;
  logic [LUT_AW-1:0] TargetIdx;
  logic              HaltReq;
  logic              LutWe;
  logic [LUT_AW-1:0] LutAddr;
  logic [PC_W-1:0]   LutData;
  logic [PC_W-1:0]   ProgCtr;
  logic              Running;
  logic              Done;
  logic [CNT_W-1:0]  BranchCnt;

  // Sequencer / control side: drives controls, observes the fetch state.
  modport master (
    output Start, StartAddr, Jump, BranchEn, Zero, TargetIdx, HaltReq,
    output LutWe, LutAddr, LutData,
    input  ProgCtr, Running, Done, BranchCnt
  );

  // Fetch unit side.
  modport slave (
    input  Start, StartAddr, Jump, BranchEn, Zero, TargetIdx, HaltReq,
    input  LutWe, LutAddr, LutData,
    output ProgCtr, Running, Done, BranchCnt
  );

endinterface

// File: rtl/fetch_unit.sv
// PC sequencer with IDLE/RUN/DONE control and a writable jump/branch target LUT.
// Latency: one cycle from sampled control to registered ProgCtr/Running/Done; taken transfers add no bubble.
// Backpressure: none; one instruction per cycle while running. Optional taken counter: FETCH_BRANCH_CNT_EN.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  fetch_unit_if.slave  bus
);

  localparam int LUT_N = 1 << LUT_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] lut_d [LUT_N];
  logic            taken;

  // A transfer is taken on an unconditional jump or a branch whose ALU result was zero.
  assign taken = bus.Jump | (bus.BranchEn & bus.Zero);

  // Next-state and next-PC: halt beats a taken transfer, otherwise sequential fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = bus.StartAddr;
        end
      end
      RUN: begin
        if (bus.HaltReq) begin
          state_d = DONE;
        end else if (taken) begin
          // Combinational read sees the pre-write contents, so a same-cycle write is not forwarded.
          pc_d = lut_q[bus.TargetIdx];
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Target LUT write port, active in every state.
  always_comb begin
    lut_d = lut_q;
    if (bus.LutWe) begin
      lut_d[bus.LutAddr] = bus.LutData;
    end
  end

  // State, PC and LUT registers; reset returns everything to zero immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lut_q   <= lut_d;
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.Running = (state_q == RUN);
  assign bus.Done    = (state_q == DONE);

`ifdef FETCH_BRANCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of taken, non-halting RUN cycles; cleared when a run starts.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != RUN) begin
      if (bus.Start) begin
        cnt_d = '0;
      end
    end else if (!bus.HaltReq && taken && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.BranchCnt = cnt_q;
`else
  assign bus.BranchCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random control traffic.
// Latency: expected outputs are checked one cycle after the stimulus edge.
// Backpressure: none; a monitor pops one expectation per clock.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int LUT_AW  = 5;
  localparam int CNT_W   = 8;
  localparam int LUT_N   = 1 << LUT_AW;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              st;
    logic [PC_W-1:0]   sa;
    logic              jmp;
    logic              br;
    logic              z;
    logic [LUT_AW-1:0] idx;
    logic              halt;
    logic              we;
    logic [LUT_AW-1:0] waddr;
    logic [PC_W-1:0]   wdata;
  } stim_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             run;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic Clk;
  logic Reset_n;

  fetch_unit_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: plain numbers, not the DUT's encoding.
  bit m_run;
  bit m_done;
  int m_pc;
  int m_cnt;
  int m_lut [LUT_N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_done = 0;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
  endtask

  task automatic apply(input stim_t s);
    bus.Start     = s.st;
    bus.StartAddr = s.sa;
    bus.Jump      = s.jmp;
    bus.BranchEn  = s.br;
    bus.Zero      = s.z;
    bus.TargetIdx = s.idx;
    bus.HaltReq   = s.halt;
    bus.LutWe     = s.we;
    bus.LutAddr   = s.waddr;
    bus.LutData   = s.wdata;
  endtask

  // Drive one cycle of stimulus, advance the model, queue the expected outputs.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge Clk);
    apply(s);
    if (!m_run) begin
      if (s.st) begin
        m_run  = 1;
        m_done = 0;
        m_pc   = int'(s.sa);
        m_cnt  = 0;
      end
    end else if (s.halt) begin
      m_run  = 0;
      m_done = 1;
    end else if (s.jmp || (s.br && s.z)) begin
      m_pc = m_lut[s.idx];
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
    if (s.we) m_lut[s.waddr] = int'(s.wdata);
    e.pc   = PC_W'(m_pc);
    e.run  = m_run;
    e.done = m_done;
`ifdef FETCH_BRANCH_CNT_EN
    e.cnt  = CNT_W'(m_cnt);
`else
    e.cnt  = '0;
`endif
    exp_q.push_back(e);
  endtask

  function automatic stim_t rnd_stim(input int start_pct, input int halt_pct);
    stim_t s;
    s.st    = ($urandom_range(99) < start_pct);
    s.sa    = PC_W'($urandom);
    s.jmp   = ($urandom_range(3) == 0);
    s.br    = ($urandom_range(2) == 0);
    s.z     = 1'($urandom);
    s.idx   = LUT_AW'($urandom);
    s.halt  = ($urandom_range(99) < halt_pct);
    s.we    = ($urandom_range(3) == 0);
    s.waddr = LUT_AW'($urandom);
    s.wdata = PC_W'($urandom);
    return s;
  endfunction

  // Monitor: every cycle the DUT presents registered outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("prog_ctr",   32'(bus.ProgCtr),   32'(e.pc));
        chk("running",    32'(bus.Running),   32'(e.run));
        chk("done",       32'(bus.Done),      32'(e.done));
        chk("branch_cnt", 32'(bus.BranchCnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    Reset_n = 1'b0;
    apply('0);
    model_reset();
    #1;
    chk("reset_prog_ctr",   32'(bus.ProgCtr),   32'h0);
    chk("reset_running",    32'(bus.Running),   32'h0);
    chk("reset_done",       32'(bus.Done),      32'h0);
    chk("reset_branch_cnt", 32'(bus.BranchCnt), 32'h0);
    #6 Reset_n = 1'b1;

    // Start at 0x010 and free-run.
    s = '0; s.st = 1; s.sa = 10'h010; step(s);
    s = '0; repeat (3) step(s);
    // Program LUT[3]=0x200, jump through it, then fall through.
    s = '0; s.we = 1; s.waddr = 3; s.wdata = 10'h200; step(s);
    s = '0; s.jmp = 1; s.idx = 3; step(s);
    s = '0; step(s);
    // Branch not taken, then taken.
    s = '0; s.br = 1; s.z = 0; s.idx = 3; step(s);
    s = '0; s.br = 1; s.z = 1; s.idx = 3; step(s);
    // Reach 0x055, halt with a simultaneous jump, then restart at 0.
    s = '0; s.we = 1; s.waddr = 4; s.wdata = 10'h055; step(s);
    s = '0; s.jmp = 1; s.idx = 4; step(s);
    s = '0; s.halt = 1; s.jmp = 1; s.idx = 3; step(s);
    s = '0; s.jmp = 1; s.idx = 3; step(s);
    s = '0; s.st = 1; s.sa = 10'h000; step(s);
    // Wrap from the top of the address space.
    s = '0; s.halt = 1; step(s);
    s = '0; s.st = 1; s.sa = 10'h3FE; step(s);
    s = '0; step(s);
    s = '0; step(s);
    // Same-cycle write and read of LUT[3]: old value now, new value next cycle.
    s = '0; s.we = 1; s.waddr = 3; s.wdata = 10'h100; s.jmp = 1; s.idx = 3; step(s);
    s = '0; s.jmp = 1; s.idx = 3; step(s);
    // Start ignored while running.
    s = '0; s.st = 1; s.sa = 10'h2AA; step(s);

    // Long run of taken jumps drives the counter into saturation.
    s = '0; s.halt = 1; step(s);
    s = '0; s.st = 1; s.sa = 10'h005; step(s);
    for (int i = 0; i < 300; i++) begin
      s = rnd_stim(0, 0);
      s.jmp = 1;
      step(s);
    end

    // Random control traffic including halts and restarts.
    for (int i = 0; i < 1500; i++) begin
      s = rnd_stim(25, 4);
      step(s);
    end

    // Asynchronous reset in the middle of a run at 0x123.
    s = '0; s.halt = 1; step(s);
    s = '0; s.st = 1; s.sa = 10'h123; step(s);
    @(posedge Clk);
    #3;
    chk("pre_reset_prog_ctr", 32'(bus.ProgCtr), 32'h123);
    Reset_n = 1'b0;
    apply('0);
    #1;
    chk("async_reset_prog_ctr",   32'(bus.ProgCtr),   32'h0);
    chk("async_reset_running",    32'(bus.Running),   32'h0);
    chk("async_reset_done",       32'(bus.Done),      32'h0);
    chk("async_reset_branch_cnt", 32'(bus.BranchCnt), 32'h0);
    model_reset();
    #2 Reset_n = 1'b1;

    // LUT[3] must have been cleared by reset.
    s = '0; s.st = 1; s.sa = 10'h050; step(s);
    s = '0; s.jmp = 1; s.idx = 3; step(s);
    s = '0; step(s);

    @(posedge Clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
